// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - op encodings as they arrive on the op port
//   - FSM state encodings
//   - abs_w: two's-complement magnitude of a sign-extended operand
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ITER = 2'b01,
        S_FIX  = 2'b10
    } mdu_state_e;

    // Operands of any WIDTH up to 64 are sign-extended to 64 bits by the caller.
    // The caller truncates the result back to WIDTH. The most negative value
    // maps onto itself, which reads correctly as an unsigned magnitude.
    function automatic logic [63:0] abs_w(input logic [63:0] x);
        return x[63] ? (~x + 64'd1) : x;
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the multiply/divide datapath (purely combinational).
//   is_div    1      0: shift-add multiply step, 1: restoring divide step
//   acc       2W     accumulator {upper, lower}
//                      mul: {partial product, remaining multiplier bits}
//                      div: {remainder, dividend bits / quotient bits}
//   mcand     W      multiplicand magnitude (mul)
//   divisor   W      divisor magnitude (div)
//   acc_next  2W     accumulator after this step
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     divisor,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   partial;
    logic             sub_ok;
    logic [WIDTH-1:0] rem_next;

    always_comb begin
        // Multiply: add into the upper half when the current multiplier bit is
        // set, then shift the whole accumulator right; the carry becomes the MSB.
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);

        // Divide: the shifted remainder needs W+1 bits because the bit leaving
        // the top of the remainder still takes part in the trial subtraction.
        partial  = acc[2*WIDTH-1:WIDTH-1];
        sub_ok   = (partial >= {1'b0, divisor});
        // Any kept difference is below the divisor, so W-bit wrap is exact.
        rem_next = sub_ok ? (partial[WIDTH-1:0] - divisor) : partial[WIDTH-1:0];

        if (is_div) begin
            acc_next = {rem_next, acc[WIDTH-2:0], sub_ok};
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO registers.
//   clk, reset (async, active-low)
//   start, op[1:0], a, b       launch MULT/MULTU/DIV/DIVU (sampled in IDLE only)
//   hi_we/hi_wdata, lo_we/lo_wdata   MTHI/MTLO, honoured in IDLE only
//   busy      op in flight (IDLE -> ITER x WIDTH -> FIX)
//   done      one-cycle pulse after the FIX edge; hi/lo hold the result
//   div_zero  pulses with done when a divide had b==0
//   hi, lo    HI/LO registers
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] hi_wdata,
    input  logic [WIDTH-1:0] lo_wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_e         state_reg, state_next;
    logic [CW-1:0]      cnt_reg;
    logic               is_div_reg;
    logic               neg_a_reg, neg_b_reg;
    logic [WIDTH-1:0]   opa_reg, opb_reg;
    logic [2*WIDTH-1:0] acc_reg, acc_step;
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic               done_reg, div_zero_reg;

    // Operand decode at launch
    logic               op_signed, op_div;
    logic [WIDTH-1:0]   a_mag, b_mag;

    assign op_signed = (op == MDU_MULT) || (op == MDU_DIV);
    assign op_div    = (op == MDU_DIV)  || (op == MDU_DIVU);
    assign a_mag = (op_signed && a[WIDTH-1]) ? WIDTH'(abs_w(64'(signed'(a)))) : a;
    assign b_mag = (op_signed && b[WIDTH-1]) ? WIDTH'(abs_w(64'(signed'(b)))) : b;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div_reg),
        .acc      (acc_reg),
        .mcand    (opa_reg),
        .divisor  (opb_reg),
        .acc_next (acc_step)
    );

    // Sign correction applied on the FIX edge
    logic               neg_res;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, a_orig;

    always_comb begin
        neg_res  = neg_a_reg ^ neg_b_reg;
        prod_fix = neg_res ? (~acc_reg + 1'b1) : acc_reg;
        quo_fix  = neg_res ? (~acc_reg[WIDTH-1:0] + 1'b1) : acc_reg[WIDTH-1:0];
        rem_fix  = neg_a_reg ? (~acc_reg[2*WIDTH-1:WIDTH] + 1'b1) : acc_reg[2*WIDTH-1:WIDTH];
        // Original dividend, rebuilt for the divide-by-zero result
        a_orig   = neg_a_reg ? (~opa_reg + 1'b1) : opa_reg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_ITER;
            S_ITER:  if (cnt_reg == '0) state_next = S_FIX;
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg      <= '0;
            is_div_reg   <= 1'b0;
            neg_a_reg    <= 1'b0;
            neg_b_reg    <= 1'b0;
            opa_reg      <= '0;
            opb_reg      <= '0;
            acc_reg      <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (hi_we) hi_reg <= hi_wdata;
                    if (lo_we) lo_reg <= lo_wdata;
                    if (start) begin
                        is_div_reg <= op_div;
                        neg_a_reg  <= op_signed && a[WIDTH-1];
                        neg_b_reg  <= op_signed && b[WIDTH-1];
                        opa_reg    <= a_mag;
                        opb_reg    <= b_mag;
                        // Upper half cleared; lower half carries the bits that
                        // get consumed: multiplier for mul, dividend for div.
                        acc_reg    <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
                        cnt_reg    <= CW'(WIDTH - 1);
                    end
                end
                S_ITER: begin
                    acc_reg <= acc_step;
                    cnt_reg <= cnt_reg - 1'b1;
                end
                S_FIX: begin
                    done_reg <= 1'b1;
                    if (!is_div_reg) begin
                        {hi_reg, lo_reg} <= prod_fix;
                    end else if (opb_reg == '0) begin
                        hi_reg       <= a_orig;
                        lo_reg       <= '1;
                        div_zero_reg <= 1'b1;
                    end else begin
                        hi_reg <= rem_fix;
                        lo_reg <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state_reg != S_IDLE);
    assign done     = done_reg;
    assign div_zero = div_zero_reg;
    assign hi       = hi_reg;
    assign lo       = lo_reg;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter (WIDTH=32): expected {div_zero, hi, lo}
// values are computed by a behavioural model when an op is launched, queued,
// and compared when done pulses.
module tb_mdu_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0, b = '0;
    logic         hi_we = 1'b0, lo_we = 1'b0;
    logic [W-1:0] hi_wdata = '0, lo_wdata = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [64:0] exp_q[$];

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    // Returns {div_zero, hi, lo}
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        longint      sx, sy;
        int          ix, iy;
        case (o)
            2'b00: begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                p  = 64'(sx * sy);
                return {1'b0, p};
            end
            2'b01: begin
                p = {32'd0, x} * {32'd0, y};
                return {1'b0, p};
            end
            2'b10: begin
                if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
                ix = $signed(x);
                iy = $signed(y);
                return {1'b0, 32'(ix % iy), 32'(ix / iy)};
            end
            default: begin
                if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
                return {1'b0, x % y, x / y};
            end
        endcase
    endfunction

    // Drives start for one edge (E0). at_negedge=0 launches immediately,
    // used for a start in the same cycle that done is high.
    task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                            input bit at_negedge, input bit expect_result);
        if (at_negedge) @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        if (expect_result) exp_q.push_back(model(o, x, y));
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    // Waits up to 40 edges for done. interfere=1 pulses start(DIVU) and
    // hi_we on edge 5 of the op; both must be ignored.
    task automatic wait_done(input string tag, input bit interfere, input bit check_clear);
        int n = 0;
        bit seen = 0;
        logic [64:0] e;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (interfere && n == 4) begin
                start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd3;
                hi_we = 1'b1; hi_wdata = 32'h1234;
            end
            if (interfere && n == 5) begin
                start = 1'b0; hi_we = 1'b0;
                check({tag, "_busy_mid"}, busy, 1);
            end
            if (done) seen = 1;
        end
        check({tag, "_latency"}, 64'(n), 64'd33);
        if (seen && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_hi"}, hi, e[63:32]);
            check({tag, "_lo"}, lo, e[31:0]);
            check({tag, "_div_zero"}, div_zero, e[64]);
            check({tag, "_busy_with_done"}, busy, 0);
            $display("op %s: hi=%h lo=%h div_zero=%0d after %0d edges", tag, hi, lo, div_zero, n);
        end else begin
            check({tag, "_done_seen"}, 64'(seen), 64'd1);
        end
        if (check_clear) begin
            @(posedge clk); #1;
            check({tag, "_done_pulse"}, done, 0);
            check({tag, "_div_zero_pulse"}, div_zero, 0);
            check({tag, "_idle"}, busy, 0);
        end
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_a, r_b;

        repeat (2) @(posedge clk);
        #1;
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        @(negedge clk); reset = 1'b1;

        // 1. signed multiply with mixed signs
        start_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1, 1);
        wait_done("mult_neg3x5", 0, 1);

        // 2. largest unsigned product, then same bits as signed (-1 * -1)
        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1);
        wait_done("multu_max", 0, 0);
        start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1);  // back-to-back
        wait_done("mult_m1xm1", 0, 1);

        // 3. signed and unsigned divide of -7 by 2
        start_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1, 1);
        wait_done("div_m7_2", 0, 1);
        start_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1, 1);
        wait_done("divu_m7_2", 0, 1);

        // 4. divide by zero and the MIN/-1 overflow case
        start_op(2'b11, 32'd7, 32'd0, 1, 1);
        wait_done("divu_by0", 0, 1);
        start_op(2'b10, 32'hFFFF_FFF9, 32'd0, 1, 1);
        wait_done("div_neg_by0", 0, 1);
        start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1);
        wait_done("div_min_m1", 0, 1);

        // 5. start/MTHI while busy are ignored; MTLO in IDLE lands next edge
        start_op(2'b00, 32'h0001_2345, 32'hFFFF_FF00, 1, 1);
        wait_done("mult_interfere", 1, 1);
        @(negedge clk); lo_we = 1'b1; lo_wdata = 32'hABCD;
        @(posedge clk); #1; lo_we = 1'b0;
        check("mtlo_lo", lo, 32'hABCD);
        check("mtlo_busy", busy, 0);
        // MTHI together with start: the write lands, then the result overwrites it
        @(negedge clk); hi_we = 1'b1; hi_wdata = 32'h5555;
        start_op(2'b01, 32'd3, 32'd4, 0, 1);
        hi_we = 1'b0;
        check("mthi_with_start", hi, 32'h5555);
        wait_done("multu_after_mthi", 0, 1);

        // Random mix of all four ops, including zero divisors
        for (int i = 0; i < 8; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            r_b  = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000)));
            start_op(r_op, r_a, r_b, 1, 1);
            wait_done($sformatf("rand%0d_op%0d", i, r_op), 0, 1);
        end

        // 6. reset mid-divide: state cleared at once, no done pulse
        start_op(2'b10, 32'd1000, 32'd7, 1, 0);
        repeat (9) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        #1;
        check("midreset_hi", hi, 0);
        check("midreset_lo", lo, 0);
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("midreset_hold_done", done, 0);
        end
        @(negedge clk); reset = 1'b1;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk); #1;
            check("no_late_done", done, 0);
        end
        start_op(2'b01, 32'd6, 32'd7, 1, 1);
        wait_done("multu_6x7", 0, 1);

        check("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
